dot_seq: RTL and testbench

Sequencer that time-shares one registered 8x8 unsigned multiplier to compute a dot product of two streamed operand vectors.
- Accepts a run length and a start command, then pulls operand pairs over a valid/ready stream.
- Issues each pair to the multiplier and accumulates the products.
- Presents the sum on a valid/ready result port.
- Sits between the operand fetch logic and the result writeback in the matmul datapath.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/mul_stage.sv | 29 ++
 rtl/dot_seq.sv | 127 ++++++++++++
 tb/tb_dot_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared widths and state encoding for the matmul datapath blocks.
package matmul_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 32;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/mul_stage.sv
// Registered unsigned multiplier with one-cycle latency; flush drops the pending product.
module mul_stage #(
    parameter int DW = matmul_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_in,
    input  logic              flush,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic              vld_out,
    output logic [2*DW-1:0]   p
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_out <= 1'b0;
            p       <= '0;
        end else if (flush) begin
            vld_out <= 1'b0;
        end else begin
            vld_out <= vld_in;
            if (vld_in) begin
                p <= (2*DW)'(a) * (2*DW)'(b);
            end
        end
    end

endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer: streams operand pairs through one registered multiplier
// and accumulates the products into a result handed off over valid/ready.
module dot_seq #(
    parameter int DATA_W = matmul_pkg::DATA_W,
    parameter int LEN_W  = matmul_pkg::LEN_W,
    parameter int ACC_W  = matmul_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              busy
);
    import matmul_pkg::*;

    localparam int PW = 2 * DATA_W;

    state_t             state_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               ovf_reg;
    logic               in_ready_reg;
    logic               res_valid_reg;
    logic               busy_reg;

    logic               mul_vld;
    logic [PW-1:0]      mul_p;
    logic               beat;
    logic [ACC_W:0]     acc_sum;

    assign beat    = in_valid && in_ready_reg;
    // Extra top bit captures the carry-out that marks a wrap of the accumulator.
    assign acc_sum = {1'b0, acc_reg} + (ACC_W+1)'(mul_p);

    mul_stage #(.DW(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (beat),
        .flush   (abort),
        .a       (in_a),
        .b       (in_b),
        .vld_out (mul_vld),
        .p       (mul_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            len_reg       <= '0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (abort) begin
            // Accumulator and overflow flag keep their values; the in-flight product is dropped.
            state_reg     <= ST_IDLE;
            in_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            if (mul_vld) begin
                acc_reg <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    ovf_reg <= 1'b1;
                end
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        acc_reg  <= '0;
                        ovf_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        if (cfg_len != '0) begin
                            len_reg      <= cfg_len;
                            cnt_reg      <= '0;
                            in_ready_reg <= 1'b1;
                            state_reg    <= ST_RUN;
                        end else begin
                            res_valid_reg <= 1'b1;
                            state_reg     <= ST_OUT;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == len_reg - 1'b1) begin
                            in_ready_reg <= 1'b0;
                            state_reg    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    res_valid_reg <= 1'b1;
                    state_reg     <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = acc_reg;
    assign res_ovf   = ovf_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_dot_seq.sv
// Scoreboard bench for dot_seq: a 32-bit and a 16-bit accumulator instance run the same stimulus.
module tb_dot_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;

    logic        in_ready32, res_valid32, res_ovf32, busy32;
    logic [31:0] res_data32;
    logic        in_ready16, res_valid16, res_ovf16, busy16;
    logic [15:0] res_data16;

    always #5 clk = ~clk;

    dot_seq u_dut32 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready32), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid32), .res_ready(res_ready), .res_data(res_data32),
        .res_ovf(res_ovf32), .busy(busy32)
    );

    dot_seq #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid16), .res_ready(res_ready), .res_data(res_data16),
        .res_ovf(res_ovf16), .busy(busy16)
    );

    typedef struct {
        longint d32;
        bit     o32;
        longint d16;
        bit     o16;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     va[16];
    int     vb[16];
    int     n_tests = 0;
    int     n_fail = 0;
    int     beat_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitor: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst && in_valid && in_ready32) beat_cnt++;
        if (rst && res_valid32 && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data32", 64'(res_data32), 64'(mon_e.d32));
                check("res_ovf32",  64'(res_ovf32),  64'(mon_e.o32));
                check("res_valid16", 64'(res_valid16), 64'd1);
                check("res_data16", 64'(res_data16), 64'(mon_e.d16));
                check("res_ovf16",  64'(res_ovf16),  64'(mon_e.o16));
                $display("[TB] result len-run: data32=%0d ovf32=%0d data16=%0d ovf16=%0d",
                         res_data32, res_ovf32, res_data16, res_ovf16);
            end
        end
    end

    task automatic push_exp(input int len);
        longint a32 = 0;
        longint a16 = 0;
        bit     o32 = 0;
        bit     o16 = 0;
        longint p;
        exp_t   e;
        for (int i = 0; i < len; i++) begin
            p = longint'(va[i]) * longint'(vb[i]);
            a32 += p;
            if (a32 >= (64'd1 << 32)) begin
                a32 -= (64'd1 << 32);
                o32 = 1;
            end
            a16 += p;
            if (a16 >= 65536) begin
                a16 -= 65536;
                o16 = 1;
            end
        end
        e = '{a32, o32, a16, o16};
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int len);
        check("idle_before_start", 64'(busy32), 64'd0);
        start = 1'b1;
        cfg_len = 8'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int len, input bit gap, input bit poke);
        int i = 0;
        int guard = 0;
        bit rdy;
        while (i < len && guard < 200) begin
            in_valid = gap ? ((guard % 2) == 0) : 1'b1;
            in_a = 8'(va[i]);
            in_b = 8'(vb[i]);
            start = poke && (i == 1);
            if (poke && i == 1) cfg_len = 8'd3;
            rdy = in_ready32;
            tick();
            guard++;
            if (rdy && in_valid) i++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (i < len) check("feed_timeout", 64'(i), 64'(len));
    endtask

    task automatic finish_res(input int hold);
        logic [31:0] d0;
        d0 = res_data32;
        for (int k = 0; k < hold; k++) begin
            res_ready = 1'b0;
            tick();
            check("hold_valid", 64'(res_valid32), 64'd1);
            check("hold_data", 64'(res_data32), 64'(d0));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_drop", 64'(res_valid32), 64'd0);
        check("busy_drop", 64'(busy32), 64'd0);
        check("data_retain", 64'(res_data32), 64'(d0));
    endtask

    task automatic run(input int len, input bit gap, input bit poke, input int hold);
        int b0;
        push_exp(len);
        do_start(len);
        check("in_ready_up", 64'(in_ready32), 64'd1);
        check("busy_up", 64'(busy16), 64'd1);
        b0 = beat_cnt;
        feed(len, gap, poke);
        // Keep offering junk data: no further beat may be taken.
        in_valid = 1'b1;
        in_a = 8'hEE;
        in_b = 8'hEE;
        check("lat_edge1", 64'(res_valid32), 64'd0);
        check("drain_ready", 64'(in_ready32), 64'd0);
        tick();
        check("lat_edge2", 64'(res_valid32), 64'd1);
        check("lat_edge2_16", 64'(res_valid16), 64'd1);
        in_valid = 1'b0;
        check("beats_taken", 64'(beat_cnt - b0), 64'(len));
        finish_res(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_in_ready", 64'(in_ready32), 64'd0);
        check("rst_res_valid", 64'(res_valid32), 64'd0);
        check("rst_res_data", 64'(res_data32), 64'd0);
        check("rst_busy", 64'(busy32), 64'd0);
        rst = 1'b1;
        tick();

        // Basic run: 1*5+2*6+3*7+4*8 = 70
        for (int i = 0; i < 4; i++) begin va[i] = i + 1; vb[i] = i + 5; end
        run(4, 1'b0, 1'b0, 0);

        // Max operands with input gaps, then result backpressure.
        for (int i = 0; i < 4; i++) begin va[i] = 255; vb[i] = 255; end
        run(4, 1'b1, 1'b0, 5);

        // Overflow in the 16-bit instance, then flag cleared on next run.
        run(2, 1'b0, 1'b0, 0);
        va[0] = 2; vb[0] = 3;
        run(1, 1'b0, 1'b0, 0);

        // Zero-length run.
        push_exp(0);
        do_start(0);
        check("zl_valid", 64'(res_valid32), 64'd1);
        check("zl_in_ready", 64'(in_ready32), 64'd0);
        check("zl_data", 64'(res_data32), 64'd0);
        finish_res(0);

        // Abort coincident with a beat after three beats.
        for (int i = 0; i < 8; i++) begin va[i] = i + 1; vb[i] = 2; end
        do_start(8);
        feed(3, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a = 8'd4;
        in_b = 8'd2;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_ready", 64'(in_ready32), 64'd0);
        check("abort_valid", 64'(res_valid32), 64'd0);
        check("abort_keep_acc", 64'(res_data32), 64'd6);
        tick();
        check("abort_no_result", 64'(res_valid32), 64'd0);

        // Follow-up run with a start pulse mid-run that must be ignored.
        va[0] = 10; vb[0] = 10; va[1] = 1; vb[1] = 1;
        run(2, 1'b0, 1'b1, 0);

        // Asynchronous reset during DRAIN with a product pending.
        va[0] = 5; vb[0] = 6; va[1] = 7; vb[1] = 8;
        do_start(2);
        feed(2, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy32), 64'd0);
        check("arst_ready", 64'(in_ready32), 64'd0);
        check("arst_valid", 64'(res_valid32), 64'd0);
        check("arst_data", 64'(res_data32), 64'd0);
        check("arst_data16", 64'(res_data16), 64'd0);
        check("arst_ovf", 64'(res_ovf16), 64'd0);
        #3 rst = 1'b1;
        tick();
        check("arst_still_idle", 64'(res_valid32), 64'd0);
        va[0] = 3; vb[0] = 4;
        run(1, 1'b0, 1'b0, 0);

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
